// File: rtl/mrcd_pkg.sv
// Shared types and helpers for multi_rate_counter_display.
// - digit_t      : one hex/BCD digit
// - seg_glyph    : 4-bit value -> active-low {g,f,e,d,c,b,a}
// - default_div  : reset divider for channel k (CLK_HZ/(5*(k+1)) - 1)
// - scan_div     : cycles per display scan step (never below 1)
// - sel_width    : width of the channel-select bus (at least 1)
package mrcd_pkg;

  typedef logic [3:0] digit_t;

  function automatic logic [6:0] seg_glyph(input digit_t val);
    logic [6:0] g;
    g = 7'h7f;
    case (val)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'ha: g = 7'h08;
      4'hb: g = 7'h03;
      4'hc: g = 7'h46;
      4'hd: g = 7'h21;
      4'he: g = 7'h06;
      4'hf: g = 7'h0e;
      default: g = 7'h7f;
    endcase
    return g;
  endfunction

  function automatic int unsigned default_div(input int unsigned clk_hz, input int unsigned k);
    return (clk_hz / (5 * (k + 1))) - 1;
  endfunction

  function automatic int unsigned scan_div(input int unsigned clk_hz, input int unsigned scan_hz);
    int unsigned r;
    r = clk_hz / scan_hz;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_rate_counter_display_rate_channel.sv
// rate_channel: one channel of the rate counter.
// Holds a programmable divider, a prescaler counting 0..div, and a single
// hex/BCD digit that steps up or down on each tick.
// Ports:
//   clk, rst_n       - clock, internal async active-low reset
//   run              - enables the prescaler
//   zero             - synchronous clear of prescaler and digit
//   dir              - 0 = count up, 1 = count down
//   chain_sel        - 0 = step on own prescaler tick, 1 = step on chain_in
//   chain_in         - carry/borrow from the previous channel
//   wr_en, wr_val    - divider write; also clears the prescaler
//   digit            - current digit value
//   carry            - one-cycle carry (up) or borrow (down) out
module rate_channel
  import mrcd_pkg::*;
#(
  parameter int unsigned      DIV_W   = 24,
  parameter int unsigned      MODULUS = 10,
  parameter logic [DIV_W-1:0] DIV_RST = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             zero,
  input  logic             dir,
  input  logic             chain_sel,
  input  logic             chain_in,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_val,
  output digit_t           digit,
  output logic             carry
);

  localparam digit_t DigitMax = digit_t'(MODULUS - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pre_q, pre_d;
  digit_t           cnt_q, cnt_d;
  logic             pre_tick;
  logic             step;

  always_comb begin
    div_d    = div_q;
    pre_d    = pre_q;
    cnt_d    = cnt_q;
    pre_tick = 1'b0;
    step     = 1'b0;
    carry    = 1'b0;
    if (zero) begin
      pre_d = '0;
      cnt_d = '0;
    end else begin
      if (wr_en) begin
        div_d = wr_val;
        pre_d = '0;
      end else if (run) begin
        if (pre_q == div_q) begin
          pre_d    = '0;
          pre_tick = 1'b1;
        end else begin
          pre_d = pre_q + DIV_W'(1);
        end
      end
      // A write to this channel swallows whatever tick lands in the same cycle.
      step = ~wr_en & (chain_sel ? chain_in : pre_tick);
      if (step) begin
        if (!dir) begin
          if (cnt_q == DigitMax) begin
            cnt_d = '0;
            carry = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          if (cnt_q == '0) begin
            cnt_d = DigitMax;
            carry = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= DIV_RST;
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

  assign digit = cnt_q;

endmodule

// File: rtl/multi_rate_counter_display.sv
// multi_rate_counter_display: N independent rate counters shown on a
// multiplexed common-anode seven-segment display, all on one clock.
// Ports:
//   clk      - system clock
//   clr      - async active-low clear (release synchronised internally)
//   run      - lets prescalers/counters advance
//   zero     - synchronous clear of all counts and prescalers
//   dir      - per-channel direction, 1 = down
//   div_we/div_sel/div_val - divider write port
//   count    - all digits, channel k at [4k+3:4k]
//   anode    - active-low digit select, bit 0 rightmost
//   cathode  - active-low {dp,g,f,e,d,c,b,a}
// Build option: define MRCD_CASCADE_EN to chain the channels into one
// NUM_DIGITS-digit counter driven by channel 0's prescaler.
module multi_rate_counter_display
  import mrcd_pkg::*;
#(
  parameter int unsigned  CLK_HZ     = 5_000_000,
  parameter int unsigned  SCAN_HZ    = 1000,
  parameter int unsigned  NUM_DIGITS = 4,
  parameter int unsigned  DIV_W      = 24,
  parameter int unsigned  MODULUS    = 10,
  localparam int unsigned SEL_W      = sel_width(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    run,
  input  logic                    zero,
  input  logic [NUM_DIGITS-1:0]   dir,
  input  logic                    div_we,
  input  logic [SEL_W-1:0]        div_sel,
  input  logic [DIV_W-1:0]        div_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              cathode
);

  localparam int unsigned SCAN_DIV = scan_div(CLK_HZ, SCAN_HZ);
  localparam int unsigned SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // Assert asynchronously, release two clocks after clr rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_ch
    logic   wr_k;
    logic   chain_k;
    logic   carry_k;
    digit_t digit_k;

    // Selects at or above NUM_DIGITS match no channel and are dropped.
    assign wr_k = div_we && (div_sel == SEL_W'(k));

`ifdef MRCD_CASCADE_EN
    localparam logic ChainSel = (k != 0);
    if (k == 0) begin : g_head
      assign chain_k = 1'b0;
    end else begin : g_link
      assign chain_k = g_ch[k-1].carry_k;
    end
`else
    localparam logic ChainSel = 1'b0;
    logic carry_unused;
    assign chain_k      = 1'b0;
    assign carry_unused = carry_k;
`endif

    rate_channel #(
      .DIV_W   (DIV_W),
      .MODULUS (MODULUS),
      .DIV_RST (DIV_W'(default_div(CLK_HZ, k)))
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .zero      (zero),
      .dir       (dir[k]),
      .chain_sel (ChainSel),
      .chain_in  (chain_k),
      .wr_en     (wr_k),
      .wr_val    (div_val),
      .digit     (digit_k),
      .carry     (carry_k)
    );

    assign count[4*k +: 4] = digit_k;
  end

  // Display scan: free-running, independent of run.
  logic [SCAN_W-1:0]     scan_pre_q, scan_pre_d;
  logic [SEL_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [7:0]            cathode_q, cathode_d;
  logic                  scan_tick;
  digit_t                cur_digit;

  always_comb begin
    scan_tick  = (scan_pre_q == SCAN_W'(SCAN_DIV - 1));
    scan_pre_d = scan_tick ? '0 : scan_pre_q + SCAN_W'(1);
    idx_d      = idx_q;
    anode_d    = anode_q;
    cathode_d  = cathode_q;
    cur_digit  = count[{idx_q, 2'b00} +: 4];
    // Light the current index with pre-edge count, then move to the next one.
    if (scan_tick) begin
      anode_d   = ~(NUM_DIGITS'(1) << idx_q);
      cathode_d = {~dir[idx_q], seg_glyph(cur_digit)};
      idx_d     = (idx_q == SEL_W'(NUM_DIGITS - 1)) ? '0 : idx_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_pre_q <= '0;
      idx_q      <= '0;
      anode_q    <= '1;
      cathode_q  <= 8'hff;
    end else begin
      scan_pre_q <= scan_pre_d;
      idx_q      <= idx_d;
      anode_q    <= anode_d;
      cathode_q  <= cathode_d;
    end
  end

  assign anode   = anode_q;
  assign cathode = cathode_q;

endmodule

// File: tb/tb_multi_rate_counter_display.sv
// Bench for multi_rate_counter_display at CLK_HZ=100, SCAN_HZ=50, 4 digits, BCD.
// Default dividers are 19, 9, 5, 4; one scan step every 2 cycles.
module tb_multi_rate_counter_display;

  logic        clk = 1'b0;
  logic        clr;
  logic        run;
  logic        zero;
  logic [3:0]  dir;
  logic        div_we;
  logic [1:0]  div_sel;
  logic [23:0] div_val;
  logic [15:0] count;
  logic [3:0]  anode;
  logic [7:0]  cathode;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_rate_counter_display #(
    .CLK_HZ     (100),
    .SCAN_HZ    (50),
    .NUM_DIGITS (4),
    .DIV_W      (24),
    .MODULUS    (10)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .run     (run),
    .zero    (zero),
    .dir     (dir),
    .div_we  (div_we),
    .div_sel (div_sel),
    .div_val (div_val),
    .count   (count),
    .anode   (anode),
    .cathode (cathode)
  );

  typedef struct {
    int          cycles;
    logic        run;
    logic [3:0]  dir;
    logic        zero;
    logic        we;
    logic [1:0]  sel;
    logic [23:0] val;
    logic [15:0] exp;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    run = 1'b0; zero = 1'b0; div_we = 1'b0; div_sel = '0; div_val = '0; dir = '0;
    clr = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic write_div(input logic [1:0] sel, input logic [23:0] val);
    div_sel = sel; div_val = val; div_we = 1'b1;
    @(negedge clk);
    div_we = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    run = 1'b1;
    repeat (n) @(negedge clk);
    run = 1'b0;
  endtask

  initial begin
    vec_t       vecs[12];
    logic [3:0] prev;
    int         changes;
    int         hit1;

    // Reset values and first scan step (2 cycles after internal release).
    do_reset();
    check("rst_count", count, 16'h0000);
    check("rst_anode", anode, 4'hf);
    check("rst_cathode", cathode, 8'hff);
    @(negedge clk);
    check("scan_still_blank", anode, 4'hf);
    @(negedge clk);
    check("first_lit_anode", anode, 4'b1110);
    check("first_lit_cathode", cathode, 8'hc0);

`ifdef MRCD_CASCADE_EN
    write_div(2'd0, 24'd0);
    run_cycles(999);
    check("casc_0999", count, 16'h0999);
    run_cycles(1);
    check("casc_1000", count, 16'h1000);
    run_cycles(8999);
    check("casc_9999", count, 16'h9999);
    run_cycles(1);
    check("casc_wrap", count, 16'h0000);
`else
    //          cyc run dir     zero we sel val    exp
    vecs[0]  = '{100, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 24'd0, 16'h0605, "default_rates"};
    vecs[1]  = '{1,   1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 24'd0, 16'h0000, "zero_clear"};
    vecs[2]  = '{3,   1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 24'd0, 16'h0000, "pre_run3"};
    vecs[3]  = '{1,   1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 24'd5, 16'h0000, "write_ch2"};
    vecs[4]  = '{1,   1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 24'd0, 16'h1000, "ch3_tick"};
    vecs[5]  = '{5,   1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 24'd0, 16'h2110, "after_write"};
    vecs[6]  = '{9,   1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 24'd0, 16'h3210, "to_terminal"};
    vecs[7]  = '{1,   1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 24'd2, 16'h4220, "write_suppress"};
    vecs[8]  = '{3,   1'b1, 4'b0010, 1'b0, 1'b0, 2'd0, 24'd0, 16'h4321, "new_div_ch0"};
    vecs[9]  = '{7,   1'b1, 4'b0010, 1'b0, 1'b0, 2'd0, 24'd0, 16'h6413, "down_ch1"};
    vecs[10] = '{10,  1'b1, 4'b0010, 1'b0, 1'b0, 2'd0, 24'd0, 16'h8606, "down_to_0"};
    vecs[11] = '{10,  1'b1, 4'b0010, 1'b0, 1'b0, 2'd0, 24'd0, 16'h0790, "borrow_wrap"};

    for (int i = 0; i < 12; i++) begin
      run = vecs[i].run; dir = vecs[i].dir; zero = vecs[i].zero;
      div_we = vecs[i].we; div_sel = vecs[i].sel; div_val = vecs[i].val;
      for (int c = 0; c < vecs[i].cycles; c++) begin
        @(negedge clk);
        zero = 1'b0;
        div_we = 1'b0;
      end
      run = 1'b0;
      check(vecs[i].name, count, vecs[i].exp);
    end

    // Counts are ch3..ch0 = 0,7,9,0 with ch1 counting down: dp lit on digit 1.
    hit1 = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (anode == 4'b1101) begin
        hit1 = hit1 + 1;
        check("dp_digit1", cathode, 8'h10);
      end
      if (anode == 4'b1011) check("glyph_digit2", cathode, 8'hf8);
    end
    check("digit1_scanned", (hit1 > 0), 1'b1);

    // Async clear between edges.
    #2;
    clr = 1'b0;
    #1;
    check("async_count", count, 16'h0000);
    check("async_anode", anode, 4'hf);
    check("async_cathode", cathode, 8'hff);
`endif

    // All digits = 3, then watch 8 scan steps.
    do_reset();
    for (int k = 0; k < 4; k++) write_div(2'(k), 24'd0);
    run_cycles(3);
`ifndef MRCD_CASCADE_EN
    check("all_three", count, 16'h3333);
`endif
    prev = anode;
    changes = 0;
    for (int c = 0; c < 40 && changes < 8; c++) begin
      @(negedge clk);
      if (anode != prev) begin
        check("scan_rotate", anode, {prev[2:0], prev[3]});
`ifndef MRCD_CASCADE_EN
        check("scan_glyph3", cathode, 8'hb0);
`endif
        prev = anode;
        changes = changes + 1;
      end
    end
    check("scan_steps", changes, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
